// File: rtl/exec_cc_unit.sv
// Execute-stage control for the Y86-64 pipeline: drives the ALU function select,
// holds ZF/SF/OF, evaluates cmovXX/jXX conditions and registers the E->M boundary.
module exec_cc_unit #(
  parameter int         W          = 64,
  parameter logic [3:0] ICODE_OPQ  = 4'h6,
  parameter logic [3:0] ICODE_JXX  = 4'h7,
  parameter logic [3:0] ICODE_CMOV = 4'h2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         stall,
  input  logic         flush,
  input  logic         exc_block,
  output logic [1:0]   alu_ctrl,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         cnd,
  output logic         bad_ifun,
  output logic         m_valid,
  output logic         m_cnd,
  output logic [W-1:0] m_result
);

  // Flow control: an instruction moves into E->M on any edge where valid_in is
  // high and stall is low; stall holds E->M, flush overrides stall with a bubble.
  logic         zf_q, zf_d;
  logic         sf_q, sf_d;
  logic         of_q, of_d;
  logic         m_valid_q, m_valid_d;
  logic         m_cnd_q, m_cnd_d;
  logic [W-1:0] m_result_q, m_result_d;

  logic is_opq;
  logic is_cond;
  logic lt;
  logic cond_eval;
  logic set_cc;

  always_comb begin
    is_opq   = (icode == ICODE_OPQ);
    is_cond  = (icode == ICODE_JXX) || (icode == ICODE_CMOV);
    alu_ctrl = is_opq ? ifun[1:0] : 2'b00;
    bad_ifun = (is_opq && (ifun > 4'd3)) || (is_cond && (ifun > 4'd6));
  end

  // Conditions read the pre-update flags; cond instructions never write CC.
  always_comb begin
    lt        = sf_q ^ of_q;
    cond_eval = 1'b0;
    case (ifun)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = lt | zf_q;
      4'd2:    cond_eval = lt;
      4'd3:    cond_eval = zf_q;
      4'd4:    cond_eval = ~zf_q;
      4'd5:    cond_eval = ~lt;
      4'd6:    cond_eval = ~lt & ~zf_q;
      default: cond_eval = 1'b0;
    endcase
    if (!valid_in)     cnd = 1'b0;
    else if (!is_cond) cnd = 1'b1;
    else               cnd = cond_eval;
  end

  always_comb begin
    set_cc = valid_in & is_opq & ~bad_ifun & ~stall & ~flush & ~exc_block & ~rst;
    zf_d   = zf_q;
    sf_d   = sf_q;
    of_d   = of_q;
    if (set_cc) begin
      zf_d = (alu_result == '0);
      sf_d = alu_result[W-1];
      of_d = alu_overflow;
    end
  end

  always_comb begin
    m_valid_d  = m_valid_q;
    m_cnd_d    = m_cnd_q;
    m_result_d = m_result_q;
    if (flush) begin
      m_valid_d  = 1'b0;
      m_cnd_d    = 1'b0;
      m_result_d = '0;
    end else if (!stall) begin
      m_valid_d  = valid_in & ~bad_ifun;
      m_cnd_d    = cnd;
      m_result_d = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q       <= 1'b1;
      sf_q       <= 1'b0;
      of_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      m_cnd_q    <= 1'b0;
      m_result_q <= '0;
    end else begin
      zf_q       <= zf_d;
      sf_q       <= sf_d;
      of_q       <= of_d;
      m_valid_q  <= m_valid_d;
      m_cnd_q    <= m_cnd_d;
      m_result_q <= m_result_d;
    end
  end

  assign zf       = zf_q;
  assign sf       = sf_q;
  assign of       = of_q;
  assign m_valid  = m_valid_q;
  assign m_cnd    = m_cnd_q;
  assign m_result = m_result_q;

endmodule

// File: tb/tb_exec_cc_unit.sv
// Bench for exec_cc_unit: directed plan steps followed by random instructions,
// each checked against a flag/pipeline reference model.
module tb_exec_cc_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic        stall;
  logic        flush;
  logic        exc_block;
  logic [1:0]  alu_ctrl;
  logic        zf, sf, of, cnd, bad_ifun;
  logic        m_valid, m_cnd;
  logic [63:0] m_result;

  exec_cc_unit #(.W(64)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .icode(icode), .ifun(ifun),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .stall(stall),
    .flush(flush), .exc_block(exc_block), .alu_ctrl(alu_ctrl), .zf(zf),
    .sf(sf), .of(of), .cnd(cnd), .bad_ifun(bad_ifun), .m_valid(m_valid),
    .m_cnd(m_cnd), .m_result(m_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural flags and the E->M contents.
  bit          r_zf = 1'b1, r_sf = 1'b0, r_of = 1'b0;
  bit          r_mv = 1'b0, r_mc = 1'b0;
  logic [63:0] r_mr = 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] f);
    bit less;
    less = (r_sf != r_of);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return less || r_zf;
      4'd2:    return less;
      4'd3:    return r_zf;
      4'd4:    return !r_zf;
      4'd5:    return !less;
      4'd6:    return !less && !r_zf;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction: drive at negedge, check combinational outputs, then
  // check the registered state after the following rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] ic,
                      input logic [3:0] fn, input logic [63:0] res, input logic ov,
                      input logic st, input logic fl, input logic ex);
    bit is_cond, e_bad, e_cnd, upd;
    logic [1:0] e_ctrl;
    rst = r; valid_in = v; icode = ic; ifun = fn; alu_result = res;
    alu_overflow = ov; stall = st; flush = fl; exc_block = ex;
    #1;
    is_cond = (ic == 4'h7) || (ic == 4'h2);
    e_ctrl  = (ic == 4'h6) ? fn[1:0] : 2'b00;
    e_bad   = ((ic == 4'h6) && (fn > 4'd3)) || (is_cond && (fn > 4'd6));
    e_cnd   = !v ? 1'b0 : (!is_cond ? 1'b1 : ref_cond(fn));
    check("alu_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
    check("bad_ifun", 64'(bad_ifun), 64'(e_bad));
    check("cnd", 64'(cnd), 64'(e_cnd));
    upd = !r && v && (ic == 4'h6) && !e_bad && !st && !fl && !ex;
    @(posedge clk);
    #1;
    if (r) begin
      r_zf = 1; r_sf = 0; r_of = 0; r_mv = 0; r_mc = 0; r_mr = 64'd0;
    end else begin
      if (upd) begin
        r_zf = (res == 64'd0);
        r_sf = ($signed(res) < 0);
        r_of = ov;
      end
      if (fl) begin
        r_mv = 0; r_mc = 0; r_mr = 64'd0;
      end else if (!st) begin
        r_mv = v && !e_bad; r_mc = e_cnd; r_mr = res;
      end
    end
    check("zf", 64'(zf), 64'(r_zf));
    check("sf", 64'(sf), 64'(r_sf));
    check("of", 64'(of), 64'(r_of));
    check("m_valid", 64'(m_valid), 64'(r_mv));
    check("m_cnd", 64'(m_cnd), 64'(r_mc));
    check("m_result", m_result, r_mr);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  ric, rfn;
    logic [63:0] rres;
    rst = 1; valid_in = 0; icode = 0; ifun = 0; alu_result = 0;
    alu_overflow = 0; stall = 0; flush = 0; exc_block = 0;
    @(negedge clk);
    step(1, 0, 4'h0, 4'h0, 64'd0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 64'd0, 0, 0, 0, 0);
    check("reset_zf", 64'(zf), 64'd1);
    check("idle_cnd", 64'(cnd), 64'd0);

    // OPq add overflowing into the sign bit
    step(0, 1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1, 0, 0, 0);
    check("add_sf", 64'(sf), 64'd1);
    check("add_of", 64'(of), 64'd1);
    check("add_mres", m_result, 64'h8000_0000_0000_0000);

    // sub to zero, then je / jne
    step(0, 1, 4'h6, 4'h1, 64'd0, 0, 0, 0, 0);
    step(0, 1, 4'h7, 4'h3, 64'h40, 0, 0, 0, 0);
    check("je_mcnd", 64'(m_cnd), 64'd1);
    step(0, 1, 4'h7, 4'h4, 64'h40, 0, 0, 0, 0);
    check("jne_mcnd", 64'(m_cnd), 64'd0);

    // blocked CC updates
    step(0, 1, 4'h6, 4'h3, 64'd5, 0, 1, 0, 0);
    check("stall_zf", 64'(zf), 64'd1);
    step(0, 1, 4'h6, 4'h3, 64'd5, 0, 0, 0, 1);
    check("exc_zf", 64'(zf), 64'd1);
    step(0, 1, 4'h6, 4'h3, 64'd5, 0, 1, 1, 0);
    check("flush_mvalid", 64'(m_valid), 64'd0);

    // illegal function codes
    step(0, 1, 4'h2, 4'h7, 64'd9, 0, 0, 0, 0);
    check("cmov7_mvalid", 64'(m_valid), 64'd0);
    step(0, 1, 4'h6, 4'h5, 64'd0, 1, 0, 0, 0);
    check("opq5_of", 64'(of), 64'd0);

    // sf=1, of=0, zf=0 then each signed condition
    step(0, 1, 4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0);
    for (int f = 1; f <= 6; f++) step(0, 1, 4'h7, 4'(f), 64'h100, 0, 0, 0, 0);
    step(1, 1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1, 0, 0, 0);
    check("rst_op_sf", 64'(sf), 64'd0);

    // random instruction mix
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: ric = 4'h6;
        1: ric = 4'h7;
        2: ric = 4'h2;
        default: ric = 4'($urandom_range(0, 15));
      endcase
      rfn  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      rres = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) != 0), ric, rfn, rres,
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_cc_unit.md
Name: exec_cc_unit

Overview:
- Execute-stage control and condition-code block for the Y86-64 pipeline.
- Drives the ALU's 2-bit function select and consumes the ALU result and overflow flag.
- Holds the architectural condition codes ZF, SF and OF, evaluates the cmovXX/jXX condition, and registers the outcome into the E->M pipeline boundary.
- Sits between the decode/execute pipeline register and the memory stage.

Parameters:
- W, 64, datapath width of the ALU result.
- ICODE_OPQ, 4'h6, icode that updates the CCs.
- ICODE_JXX, 4'h7, icode for conditional jump.
- ICODE_CMOV, 4'h2, icode for conditional move.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  an instruction is present in execute this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- alu_result  in  W  signed result from the ALU.
- alu_overflow  in  1  signed overflow flag from the ALU.
- stall  in  1  hold the E->M register and block the CC update.
- flush  in  1  insert a bubble at E->M and block the CC update.
- exc_block  in  1  a downstream stage holds an exception; block the CC update.
- alu_ctrl  out  2  ALU function select: 00 add, 01 sub, 10 and, 11 xor.
- zf  out  1  zero flag (registered).
- sf  out  1  sign flag (registered).
- of  out  1  overflow flag (registered).
- cnd  out  1  combinational condition outcome for the current instruction.
- bad_ifun  out  1  combinational; the ifun is illegal for a cond/OPq icode.
- m_valid  out  1  registered E->M valid.
- m_cnd  out  1  registered E->M condition outcome.
- m_result  out  W  registered E->M ALU result.

Behaviour:
- alu_ctrl, combinational:
  - icode==ICODE_OPQ: alu_ctrl = ifun[1:0].
  - All other icodes: alu_ctrl = 00 (add, used for address calculation).
- bad_ifun = 1 when either holds:
  - icode==ICODE_OPQ and ifun>3.
  - icode is ICODE_JXX or ICODE_CMOV and ifun>6.
  - Otherwise bad_ifun = 0.
- Condition evaluation, combinational from the registered flags (the pre-update CC; cond instructions never set CC). ifun mapping:
  - 0 always -> 1.
  - 1 le -> (sf^of)|zf.
  - 2 l -> sf^of.
  - 3 e -> zf.
  - 4 ne -> ~zf.
  - 5 ge -> ~(sf^of).
  - 6 g -> ~(sf^of)&~zf.
  - >6 -> 0.
- cnd forcing:
  - cnd = 1 for icodes other than JXX/CMOV.
  - cnd = 0 when valid_in==0.
- CC update enable: set_cc = valid_in & icode==ICODE_OPQ & ~bad_ifun & ~stall & ~flush & ~exc_block & ~rst.
- On a clock edge with set_cc:
  - zf <= (alu_result==0).
  - sf <= alu_result[W-1].
  - of <= alu_overflow.
  - The new flags become visible the following cycle only; an instruction one cycle behind sees them.
- E->M register, priority rst > flush > stall > load:
  - rst: m_valid=0, m_cnd=0, m_result=0.
  - flush: m_valid<=0, m_cnd<=0, m_result<=0.
  - stall: all m_* hold.
  - Otherwise: m_valid<=valid_in & ~bad_ifun, m_cnd<=cnd, m_result<=alu_result.
- Reset values: zf=1, sf=0, of=0, all m_*=0. Reset asserted mid-operation discards any pending update on that edge.
- Simultaneous stall and flush: flush wins; the CC remains unchanged.
- Latency: E->M outputs are 1 cycle after the inputs. The CC is visible to cnd 1 cycle after the OPq.

Test Plan:
- Reset, then hold valid_in=0 -> zf=1, sf=0, of=0, m_valid=0, cnd=0.
- OPq add (icode 6, ifun 0), result 64'h8000000000000000, overflow=1 -> alu_ctrl=00; next cycle zf=0, sf=1, of=1, m_valid=1, m_result=64'h8000000000000000.
- OPq sub with result 0, overflow 0; next cycle jXX with ifun 3 (e) -> cnd=1, m_cnd=1. Same flags with ifun 4 (ne) -> cnd=0.
- OPq xor (ifun 3) with result 5 while stall=1 -> flags unchanged (zf=1), m_* held. Same stimulus with exc_block=1 -> flags unchanged. Same stimulus with flush=1 and stall=1 -> m_valid=0, flags unchanged.
- cmov with ifun 7 -> bad_ifun=1, cnd=0, m_valid=0. OPq with ifun 5 -> bad_ifun=1, no CC update.
- Flags sf=1, of=0, zf=0 -> jXX l (ifun 2) cnd=1, ge (ifun 5) cnd=0, le (ifun 1) cnd=1, g (ifun 6) cnd=0. Assert rst alongside an OPq -> flags return to zf=1, sf=0, of=0.
